// File: rtl/cov_pkg.sv
// Shared definitions for the covariance product streamer.
// Holds the controller state type, width defaults, and the (i,j) channel
// index tables for the 10 unique pairwise products of a 4-channel sample.
// Pair order: 11,12,13,14,22,23,24,33,34,44.
package cov_pkg;

  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned FRAC_DEF   = 8;
  localparam int unsigned WINDOW_DEF = 128;
  localparam int unsigned CHANNELS   = 4;
  localparam int unsigned PAIRS      = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StHold
  } cov_state_t;

  // First channel index of pair k.
  function automatic int unsigned pair_i(int unsigned k);
    case (k)
      0, 1, 2, 3: return 0;
      4, 5, 6:    return 1;
      7, 8:       return 2;
      default:    return 3;
    endcase
  endfunction

  // Second channel index of pair k.
  function automatic int unsigned pair_j(int unsigned k);
    case (k)
      0:       return 0;
      1, 4:    return 1;
      2, 5, 7: return 2;
      default: return 3;
    endcase
  endfunction

endpackage

// File: rtl/cov_pair_mult.sv
// Single signed Q-format multiply: full 2*DW product, arithmetic shift right
// by FRAC (floor), then reduce to DW bits.
// Build option COV_PROD_SAT_EN: when defined the shifted product is clamped
// to the DW-bit signed range; otherwise it wraps (low DW bits kept).
// Ports:
//   a_i, b_i  signed DW-bit operands
//   p_o       signed DW-bit result, same Q format as the operands
module cov_pair_mult #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] p_o
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] full;
  logic signed [PW-1:0] shifted;

  assign a_ext   = {{DW{a_i[DW-1]}}, a_i};
  assign b_ext   = {{DW{b_i[DW-1]}}, b_i};
  // |a*b| <= 2^(2*DW-2), so the low PW bits hold the exact product.
  assign full    = a_ext * b_ext;
  assign shifted = full >>> FRAC;

`ifdef COV_PROD_SAT_EN
  localparam logic signed [PW-1:0] MaxV = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW-1:0] MinV = {{(DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  always_comb begin
    p_o = shifted[DW-1:0];
    if (shifted > MaxV) begin
      p_o = MaxV[DW-1:0];
    end else if (shifted < MinV) begin
      p_o = MinV[DW-1:0];
    end
  end
`else
  logic unused_hi;

  assign p_o       = shifted[DW-1:0];
  assign unused_hi = ^shifted[PW-1:DW];
`endif

endmodule

// File: rtl/cov_product_streamer.sv
// Covariance front end: accepts 4-channel centered samples over valid/ready,
// emits the 10 unique pairwise Q-format products two cycles after each
// handshake, and frames exactly one WINDOW-sample window with en_o. After the
// last sample a 2-cycle drain flushes the pipeline, then done_o is held with
// en_o until ack_i. Products are zero on bubbles and in HOLD.
// Build option COV_PROD_SAT_EN selects saturating products (see cov_pair_mult).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             begin a window (IDLE only)
//   s_valid_i/s_ready_o sample handshake
//   x1_i..x4_i          signed samples
//   en_o                window enable to the accumulator
//   p11_o..p44_o        pairwise products
//   done_o / ack_i      window complete / consumer read it (HOLD only)
//   busy_o              not idle
//   sample_cnt_o        samples accepted in the current window
module cov_product_streamer
  import cov_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int unsigned WINDOW = WINDOW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [DW-1:0]             x1_i,
  input  logic [DW-1:0]             x2_i,
  input  logic [DW-1:0]             x3_i,
  input  logic [DW-1:0]             x4_i,
  output logic                      en_o,
  output logic [DW-1:0]             p11_o,
  output logic [DW-1:0]             p12_o,
  output logic [DW-1:0]             p13_o,
  output logic [DW-1:0]             p14_o,
  output logic [DW-1:0]             p22_o,
  output logic [DW-1:0]             p23_o,
  output logic [DW-1:0]             p24_o,
  output logic [DW-1:0]             p33_o,
  output logic [DW-1:0]             p34_o,
  output logic [DW-1:0]             p44_o,
  output logic                      done_o,
  input  logic                      ack_i,
  output logic                      busy_o,
  output logic [$clog2(WINDOW):0]   sample_cnt_o
);

  localparam int unsigned CntW = $clog2(WINDOW) + 1;
  localparam logic [CntW-1:0] WinCnt  = CntW'(WINDOW);
  localparam logic [CntW-1:0] LastCnt = CntW'(WINDOW - 1);

  cov_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic drain_q, drain_d;

  logic s_ready;
  logic hs;
  logic en;
  logic done;

  logic signed [DW-1:0] x_q    [CHANNELS];
  logic signed [DW-1:0] prod_w [PAIRS];
  logic signed [DW-1:0] p_q    [PAIRS];
  logic signed [DW-1:0] p_out  [PAIRS];

  // Controller next state and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    s_ready = 1'b0;
    hs      = 1'b0;
    en      = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        en      = 1'b1;
        s_ready = (cnt_q < WinCnt);
        hs      = s_valid_i & s_ready;
        if (hs) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end
        end
      end
      StDrain: begin
        en      = 1'b1;
        // drain_q marks the second flush cycle.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StHold;
        end
      end
      StHold: begin
        en   = 1'b1;
        done = 1'b1;
        if (ack_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Stage 1: capture samples on a handshake, zeros otherwise so bubbles
  // propagate as zero products.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        x_q[c] <= '0;
      end
    end else begin
      x_q[0] <= hs ? x1_i : '0;
      x_q[1] <= hs ? x2_i : '0;
      x_q[2] <= hs ? x3_i : '0;
      x_q[3] <= hs ? x4_i : '0;
    end
  end

  for (genvar k = 0; k < int'(PAIRS); k++) begin : g_pair
    localparam int unsigned Ci = pair_i(k);
    localparam int unsigned Cj = pair_j(k);

    cov_pair_mult #(
      .DW  (DW),
      .FRAC(FRAC)
    ) u_mult (
      .a_i(x_q[Ci]),
      .b_i(x_q[Cj]),
      .p_o(prod_w[k])
    );
  end

  // Stage 2: registered products.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(PAIRS); k++) begin
        p_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(PAIRS); k++) begin
        p_q[k] <= prod_w[k];
      end
    end
  end

  // Products are forced to zero while the matrix is being read.
  always_comb begin
    for (int k = 0; k < int'(PAIRS); k++) begin
      p_out[k] = (state_q == StHold) ? '0 : p_q[k];
    end
  end

  assign s_ready_o    = s_ready;
  assign en_o         = en;
  assign done_o       = done;
  assign busy_o       = (state_q != StIdle);
  assign sample_cnt_o = cnt_q;

  assign p11_o = p_out[0];
  assign p12_o = p_out[1];
  assign p13_o = p_out[2];
  assign p14_o = p_out[3];
  assign p22_o = p_out[4];
  assign p23_o = p_out[5];
  assign p24_o = p_out[6];
  assign p33_o = p_out[7];
  assign p34_o = p_out[8];
  assign p44_o = p_out[9];

endmodule

// File: tb/tb_cov_product_streamer.sv
// Self-checking bench for cov_product_streamer (default parameters).
// A timeline model tracks the window (open/closed, accepted count, cycle of
// the last handshake) and the samples accepted per cycle; every cycle the DUT
// outputs are compared against it on the falling edge.
module tb_cov_product_streamer;

  localparam int DW     = 16;
  localparam int FRAC   = 8;
  localparam int WINDOW = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] x1_i, x2_i, x3_i, x4_i;
  logic        en_o;
  logic [15:0] p11_o, p12_o, p13_o, p14_o, p22_o, p23_o, p24_o, p33_o, p34_o, p44_o;
  logic        done_o;
  logic        ack_i;
  logic        busy_o;
  logic [7:0]  sample_cnt_o;

  cov_product_streamer #(
    .DW    (DW),
    .FRAC  (FRAC),
    .WINDOW(WINDOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .x1_i        (x1_i),
    .x2_i        (x2_i),
    .x3_i        (x3_i),
    .x4_i        (x4_i),
    .en_o        (en_o),
    .p11_o       (p11_o),
    .p12_o       (p12_o),
    .p13_o       (p13_o),
    .p14_o       (p14_o),
    .p22_o       (p22_o),
    .p23_o       (p23_o),
    .p24_o       (p24_o),
    .p33_o       (p33_o),
    .p34_o       (p34_o),
    .p44_o       (p44_o),
    .done_o      (done_o),
    .ack_i       (ack_i),
    .busy_o      (busy_o),
    .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          PI [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int          PJ [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
  string       PN [10] = '{"p11", "p12", "p13", "p14", "p22", "p23", "p24", "p33", "p34", "p44"};
  logic [15:0] p_act [10];

  assign p_act[0] = p11_o;
  assign p_act[1] = p12_o;
  assign p_act[2] = p13_o;
  assign p_act[3] = p14_o;
  assign p_act[4] = p22_o;
  assign p_act[5] = p23_o;
  assign p_act[6] = p24_o;
  assign p_act[7] = p33_o;
  assign p_act[8] = p34_o;
  assign p_act[9] = p44_o;

  int          cyc       = 0;
  bit          m_active  = 1'b0;
  int          m_acc     = 0;
  int          m_last_hs = -100;
  logic [63:0] smp_map [int];  // accepted sample {x4,x3,x2,x1} keyed by cycle

  function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
    longint pa;
    longint pb;
    longint sh;
    logic [63:0] r;
    pa = $signed(a);
    pb = $signed(b);
    sh = (pa * pb) >>> FRAC;
`ifdef COV_PROD_SAT_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    r = sh;
    return r[15:0];
  endfunction

  function automatic bit exp_done();
    return m_active && (m_acc == WINDOW) && (cyc >= m_last_hs + 3);
  endfunction

  function automatic bit exp_ready();
    return m_active && (m_acc < WINDOW);
  endfunction

  function automatic logic [15:0] exp_p(input int k);
    logic [63:0] s;
    if (exp_done() || !smp_map.exists(cyc - 2)) return 16'h0000;
    s = smp_map[cyc - 2];
    return prod(s[16*PI[k] +: 16], s[16*PJ[k] +: 16]);
  endfunction

  always @(posedge clk) begin
    bit d;
    bit r;
    d = exp_done();
    r = exp_ready();
    if (rst) begin
      m_active = 1'b0;
      m_acc    = 0;
      smp_map.delete();
    end else if (!m_active) begin
      if (start_i) begin
        m_active = 1'b1;
        m_acc    = 0;
      end
    end else if (d) begin
      if (ack_i) m_active = 1'b0;
    end else if (r && s_valid_i) begin
      m_acc++;
      m_last_hs    = cyc;
      smp_map[cyc] = {x4_i, x3_i, x2_i, x1_i};
    end
    if (smp_map.exists(cyc - 3)) smp_map.delete(cyc - 3);
    cyc++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("en_o", en_o, m_active);
      chk("busy_o", busy_o, m_active);
      chk("s_ready_o", s_ready_o, exp_ready());
      chk("done_o", done_o, exp_done());
      chk("sample_cnt_o", sample_cnt_o, m_acc);
      for (int k = 0; k < 10; k++) begin
        chk(PN[k], p_act[k], exp_p(k));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_x();
    x1_i = 16'($urandom);
    x2_i = 16'($urandom);
    x3_i = 16'($urandom);
    x4_i = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit stalls);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      s_valid_i = stalls ? 1'($urandom) : 1'b1;
      rand_x();
      step();
      n++;
    end
    s_valid_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL wait_done: done_o=%b after %0d cycles, expected 1", done_o, n);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_i = 1'b0;
    s_valid_i = 1'b0;
    ack_i = 1'b0;
    x1_i = '0;
    x2_i = '0;
    x3_i = '0;
    x4_i = '0;
    step();
    chk_en = 1'b1;
    step();
    step();
    chk("reset_en", en_o, 0);
    chk("reset_cnt", sample_cnt_o, 0);
    chk("reset_p11", p11_o, 0);
    rst = 1'b0;
    step();

    // Basic product.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    x1_i = 16'h0100;
    x2_i = 16'h0200;
    x3_i = 16'hFF00;
    x4_i = 16'h0080;
    s_valid_i = 1'b1;
    step();
    s_valid_i = 1'b0;
    step();
    chk("lit_p11", p11_o, 16'h0100);
    chk("lit_p12", p12_o, 16'h0200);
    chk("lit_p13", p13_o, 16'hFF00);
    chk("lit_p14", p14_o, 16'h0080);
    chk("lit_p22", p22_o, 16'h0400);
    chk("lit_p23", p23_o, 16'hFE00);
    chk("lit_p24", p24_o, 16'h0100);
    chk("lit_p33", p33_o, 16'h0100);
    chk("lit_p34", p34_o, 16'hFF80);
    chk("lit_p44", p44_o, 16'h0040);

    // Overflowing products, back to back.
    x1_i = 16'h7FFF;
    s_valid_i = 1'b1;
    step();
    x1_i = 16'h8000;
    x2_i = 16'h7FFF;
    step();
    s_valid_i = 1'b0;
`ifdef COV_PROD_SAT_EN
    chk("lit_sat_p11", p11_o, 16'h7FFF);
    step();
    chk("lit_sat_p12", p12_o, 16'h8000);
`else
    chk("lit_wrap_p11", p11_o, 16'hFF00);
    step();
    chk("lit_wrap_p12", p12_o, 16'h0080);
`endif

    // Rest of the window with valid held high.
    wait_done(WINDOW + 10, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    ack_i = 1'b1;
    start_i = 1'b1;
    step();
    ack_i = 1'b0;
    start_i = 1'b0;
    chk("en_after_ack", en_o, 0);
    step();
    step();

    // Stalled window, spurious start/ack, reset at sample 60.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("cnt_new_window", sample_cnt_o, 0);
    n = 0;
    while (sample_cnt_o != 8'd60 && n < 1000) begin
      s_valid_i = 1'($urandom);
      start_i = ($urandom_range(0, 7) == 0);
      ack_i = ($urandom_range(0, 7) == 0);
      rand_x();
      step();
      n++;
    end
    chk("reached_60", sample_cnt_o, 60);
    start_i = 1'b0;
    ack_i = 1'b0;
    s_valid_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_valid_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    step();

    // Full stalled window after reset.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(2000, 1'b1);
    step();
    step();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    step();
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
